camera_mask_capture: RTL and testbench

Parametrised capture front end for the parallel YUV422 camera bus. Runs in the `pclk` domain. Tracks frame and line framing from `vsync`/`href` and extracts the luma byte of each pixel. Compares luma against a per-frame threshold to produce a 1-bit mask pixel, with the matching (x, y) frame-buffer write address. Sits between the camera pins and the mask frame buffer; replaces the free-running mask toggler.

---
 rtl/camera_pkg.sv | 26 ++
 rtl/cam_edge_detect.sv | 20 ++
 rtl/camera_mask_capture.sv | 183 ++++++++++++++++++
 tb/tb_camera_mask_capture.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and defaults for the camera capture path and the mask frame buffer.
// Byte-phase names follow the Y0,U,Y1,V order; with Y_FIRST=0 the luma sits at PH_U/PH_V.
package camera_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VBLANK,
    ST_ACTIVE
  } cam_state_e;

  typedef enum logic [1:0] {
    PH_Y0,
    PH_U,
    PH_Y1,
    PH_V
  } byte_phase_e;

  localparam int CAM_H_PIXELS       = 320;
  localparam int CAM_V_LINES        = 240;
  localparam int CAM_DEFAULT_THRESH = 80;

  function automatic logic is_luma(byte_phase_e ph, logic y_first);
    return y_first ? (ph == PH_Y0 || ph == PH_Y1) : (ph == PH_U || ph == PH_V);
  endfunction

endpackage

// File: rtl/cam_edge_detect.sv
// One-register delay of a pclk-synchronous level with rise/fall pulses.
module cam_edge_detect (
  input  logic pclk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge pclk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/camera_mask_capture.sv
// YUV422 camera front end: frame/line framing, luma extraction, per-frame
// threshold mask with (x, y) write address and sticky geometry error.
module camera_mask_capture
  import camera_pkg::*;
#(
  parameter int H_PIXELS       = CAM_H_PIXELS,
  parameter int V_LINES        = CAM_V_LINES,
  parameter int Y_FIRST        = 1,
  parameter int DEFAULT_THRESH = CAM_DEFAULT_THRESH,
  parameter int X_W            = $clog2(H_PIXELS),
  parameter int Y_W            = $clog2(V_LINES)
) (
  input  logic           pclk,
  input  logic           reset,
  input  logic           vsync,
  input  logic           href,
  input  logic [7:0]     d,
  input  logic [7:0]     thresh,
  output logic           pix_valid,
  output logic           pix_mask,
  output logic [7:0]     pix_y,
  output logic [X_W-1:0] x_addr,
  output logic [Y_W-1:0] y_addr,
  output logic           frame_start,
  output logic           frame_done,
  output logic           frame_err,
  output cam_state_e     dbg_state
);

  // Counters carry one extra bit so they can hold H_PIXELS / V_LINES exactly.
  localparam int CW = X_W + 1;
  localparam int RW = Y_W + 1;
  localparam logic [CW-1:0] H_MAX   = CW'(H_PIXELS);
  localparam logic [RW-1:0] V_MAX   = RW'(V_LINES);
  localparam logic [7:0]    T_RESET = 8'(DEFAULT_THRESH);

  logic vs_rise, vs_fall, href_rise, href_fall;

  cam_edge_detect u_vsync_edge (
    .pclk  (pclk),
    .reset (reset),
    .sig_i (vsync),
    .rise_o(vs_rise),
    .fall_o(vs_fall)
  );

  cam_edge_detect u_href_edge (
    .pclk  (pclk),
    .reset (reset),
    .sig_i (href),
    .rise_o(href_rise),
    .fall_o(href_fall)
  );

  cam_state_e     state_q, state_d;
  byte_phase_e    phase_q, phase_d, phase_cur;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [7:0]     thresh_q, thresh_d;
  logic           pix_valid_q, pix_valid_d;
  logic           pix_mask_q, pix_mask_d;
  logic [7:0]     pix_y_q, pix_y_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           fstart_q, fstart_d;
  logic           fdone_q, fdone_d;
  logic           err_q, err_d;

  // First byte of every line is forced to phase 0, independent of history.
  assign phase_cur = href_rise ? PH_Y0 : phase_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    col_d       = col_q;
    row_d       = row_q;
    thresh_d    = thresh_q;
    pix_valid_d = 1'b0;
    pix_mask_d  = pix_mask_q;
    pix_y_d     = pix_y_q;
    x_d         = x_q;
    y_d         = y_q;
    fstart_d    = 1'b0;
    fdone_d     = 1'b0;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (vsync) state_d = ST_VBLANK;
      end
      ST_VBLANK: begin
        if (vs_fall) begin
          state_d  = ST_ACTIVE;
          fstart_d = 1'b1;
          thresh_d = thresh;
          y_d      = '0;
          row_d    = '0;
          col_d    = '0;
          err_d    = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          state_d = ST_VBLANK;
          fdone_d = 1'b1;
          if (row_q != V_MAX) err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!href || state_q != ST_ACTIVE) phase_d = PH_Y0;
    else                               phase_d = byte_phase_e'(phase_cur + 2'd1);

    if (state_q == ST_ACTIVE) begin
      if (href && is_luma(phase_cur, Y_FIRST != 0)) begin
        if (col_q < H_MAX) begin
          col_d = col_q + CW'(1);
          if (row_q < V_MAX) begin
            pix_valid_d = 1'b1;
            pix_y_d     = d;
            pix_mask_d  = (d >= thresh_q);
            x_d         = col_q[X_W-1:0];
            y_d         = row_q[Y_W-1:0];
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      // Line end: rows advance only for lines that carried at least one pixel.
      if (href_fall) begin
        if (col_q != '0 && row_q < V_MAX) row_d = row_q + RW'(1);
        col_d = '0;
        if (col_q != H_MAX) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_Y0;
      col_q       <= '0;
      row_q       <= '0;
      thresh_q    <= T_RESET;
      pix_valid_q <= 1'b0;
      pix_mask_q  <= 1'b0;
      pix_y_q     <= 8'h00;
      x_q         <= '0;
      y_q         <= '0;
      fstart_q    <= 1'b0;
      fdone_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      col_q       <= col_d;
      row_q       <= row_d;
      thresh_q    <= thresh_d;
      pix_valid_q <= pix_valid_d;
      pix_mask_q  <= pix_mask_d;
      pix_y_q     <= pix_y_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fstart_q    <= fstart_d;
      fdone_q     <= fdone_d;
      err_q       <= err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_mask    = pix_mask_q;
  assign pix_y       = pix_y_q;
  assign x_addr      = x_q;
  assign y_addr      = y_q;
  assign frame_start = fstart_q;
  assign frame_done  = fdone_q;
  assign frame_err   = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_camera_mask_capture.sv
// Bench: one camera bus drives a Y_FIRST=0 and a Y_FIRST=1 capture (4x2 geometry);
// a line-level model predicts every pixel strobe, error flag and frame pulse.
module tb_camera_mask_capture;
  import camera_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int XW = 2;
  localparam int YW = 1;
  localparam int PW = 8 + 1 + XW + YW;

  typedef logic [7:0] line_t [16];

  // clock / reset
  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] thresh = 8'd80;

  always #5 pclk = ~pclk;

  logic          pv [2];
  logic          pm [2];
  logic [7:0]    py [2];
  logic [XW-1:0] xa [2];
  logic [YW-1:0] ya [2];
  logic          fs [2];
  logic          fd [2];
  logic          fe [2];
  cam_state_e    st [2];

  camera_mask_capture #(.H_PIXELS(H), .V_LINES(V), .Y_FIRST(0), .DEFAULT_THRESH(80)) dut0 (
    .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .d(d), .thresh(thresh),
    .pix_valid(pv[0]), .pix_mask(pm[0]), .pix_y(py[0]), .x_addr(xa[0]), .y_addr(ya[0]),
    .frame_start(fs[0]), .frame_done(fd[0]), .frame_err(fe[0]), .dbg_state(st[0])
  );

  camera_mask_capture #(.H_PIXELS(H), .V_LINES(V), .Y_FIRST(1), .DEFAULT_THRESH(80)) dut1 (
    .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .d(d), .thresh(thresh),
    .pix_valid(pv[1]), .pix_mask(pm[1]), .pix_y(py[1]), .x_addr(xa[1]), .y_addr(ya[1]),
    .frame_start(fs[1]), .frame_done(fd[1]), .frame_err(fe[1]), .dbg_state(st[1])
  );

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];
  bit         active = 1'b0;
  int         row_m [2];
  bit         err_m [2];
  logic [7:0] thr_m = 8'd80;
  int         start_exp = 0;
  int         done_exp = 0;
  int         start_seen [2];
  int         done_seen [2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mon(int i);
    logic [PW-1:0] got;
    logic [PW-1:0] e;
    got = {py[i], pm[i], xa[i], ya[i]};
    if (pv[i] === 1'b1) begin
      if ((i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
        chk($sformatf("pv_unexpected_dut%0d", i), 32'd1, 32'd0);
      end else begin
        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("pixel_dut%0d", i), 32'(got), 32'(e));
      end
    end
    if (fs[i] === 1'b1) begin
      start_seen[i]++;
      chk($sformatf("fstart_err_dut%0d", i), 32'(fe[i]), 32'd0);
      chk($sformatf("fstart_yaddr_dut%0d", i), 32'(ya[i]), 32'd0);
    end
    if (fd[i] === 1'b1) begin
      done_seen[i]++;
      chk($sformatf("fdone_err_dut%0d", i), 32'(fe[i]), 32'(err_m[i]));
    end
  endtask

  always @(negedge pclk) begin
    mon(0);
    mon(1);
  end

  // driver tasks
  task automatic cyc(logic v, logic h, logic [7:0] b);
    vsync = v;
    href  = h;
    d     = b;
    @(posedge pclk);
    #1;
  endtask

  task automatic push(int i, logic [7:0] b, int p);
    logic [PW-1:0] e;
    logic [XW-1:0] px;
    logic [YW-1:0] ry;
    px = p[XW-1:0];
    ry = row_m[i][YW-1:0];
    e  = {b, (b >= thr_m), px, ry};
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic do_vblank(int n, bit junk);
    if (active) begin
      for (int i = 0; i < 2; i++) if (row_m[i] != V) err_m[i] = 1'b1;
      done_exp++;
      active = 1'b0;
    end
    for (int k = 0; k < n; k++)
      cyc(1'b1, (junk && k > 0 && k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom));
    for (int i = 0; i < 2; i++) chk($sformatf("vblank_err_dut%0d", i), 32'(fe[i]), 32'(err_m[i]));
  endtask

  task automatic do_fstart();
    thr_m  = thresh;
    active = 1'b1;
    for (int i = 0; i < 2; i++) begin
      row_m[i] = 0;
      err_m[i] = 1'b0;
    end
    start_exp++;
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  // Sends n bytes then one href-low cycle; rst_at >= 0 asserts reset on that byte.
  task automatic do_line(int n, line_t b, int rst_at);
    int npix;
    for (int k = 0; k < n; k++) begin
      if (k == rst_at) begin
        reset = 1'b1;
        cyc(1'b0, 1'b1, b[k]);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("rst_outputs_dut%0d", i),
              32'({pv[i], pm[i], py[i], xa[i], ya[i], fs[i], fd[i], fe[i]}), 32'd0);
          chk($sformatf("rst_state_dut%0d", i), 32'(st[i]), 32'(ST_IDLE));
          err_m[i] = 1'b0;
        end
        chk("rst_queue_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        exp_q0.delete();
        exp_q1.delete();
        active = 1'b0;
      end else begin
        if (active) begin
          for (int i = 0; i < 2; i++) begin
            if ((k % 2) == ((i == 1) ? 0 : 1) && (k / 2) < H && row_m[i] < V) push(i, b[k], k / 2);
          end
        end
        cyc(1'b0, 1'b1, b[k]);
      end
    end
    cyc(1'b0, 1'b0, 8'h00);
    if (active) begin
      for (int i = 0; i < 2; i++) begin
        npix = (i == 1) ? (n + 1) / 2 : n / 2;
        if (npix != H) err_m[i] = 1'b1;
        if (npix > 0) begin
          if (row_m[i] >= V) err_m[i] = 1'b1;
          else               row_m[i] = row_m[i] + 1;
        end
      end
    end
    for (int i = 0; i < 2; i++) chk($sformatf("line_err_dut%0d", i), 32'(fe[i]), 32'(err_m[i]));
    repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 8'($urandom));
  endtask

  function automatic line_t pat4(logic [7:0] a0, logic [7:0] a1, logic [7:0] a2, logic [7:0] a3);
    line_t r;
    for (int k = 0; k < 16; k++) r[k] = (k % 4 == 0) ? a0 : (k % 4 == 1) ? a1 : (k % 4 == 2) ? a2 : a3;
    return r;
  endfunction

  initial begin
    line_t b;
    int    nl, n, rst_line, rst_at;
    bit    rst_frame;

    for (int i = 0; i < 2; i++) begin
      row_m[i] = 0;
      err_m[i] = 1'b0;
      start_seen[i] = 0;
      done_seen[i] = 0;
    end

    reset = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_outputs_dut%0d", i),
          32'({pv[i], pm[i], py[i], xa[i], ya[i], fs[i], fd[i], fe[i]}), 32'd0);
      chk($sformatf("reset_state_dut%0d", i), 32'(st[i]), 32'(ST_IDLE));
    end
    reset = 1'b0;

    // nominal small frame: lumas 10,90,80,79 against threshold 80
    thresh = 8'd80;
    do_vblank(4, 1'b0);
    do_fstart();
    b = pat4(8'd10, 8'd128, 8'd90, 8'd128);
    b[4] = 8'd80;
    b[6] = 8'd79;
    do_line(8, b, -1);
    do_line(8, b, -1);
    do_vblank(4, 1'b1);

    // byte order: U=200, Y=5, V=200, Y=250
    do_fstart();
    b = pat4(8'd200, 8'd5, 8'd200, 8'd250);
    do_line(8, b, -1);
    do_line(8, b, -1);
    do_vblank(5, 1'b1);

    // short line then long line
    do_fstart();
    b = pat4(8'd33, 8'd44, 8'd160, 8'd70);
    do_line(6, b, -1);
    do_line(12, b, -1);
    do_vblank(4, 1'b0);

    // threshold latch: change mid-frame, applies from next frame
    thresh = 8'd80;
    do_fstart();
    b = pat4(8'd150, 8'd150, 8'd150, 8'd150);
    do_line(8, b, -1);
    thresh = 8'd200;
    do_line(8, b, -1);
    do_vblank(4, 1'b0);
    do_fstart();
    do_line(8, b, -1);
    do_line(8, b, -1);
    do_vblank(4, 1'b1);

    // reset during pixel 2, remainder of the frame must be ignored
    thresh = 8'd100;
    do_fstart();
    b = pat4(8'd120, 8'd9, 8'd99, 8'd7);
    do_line(8, b, 4);
    do_line(8, b, -1);
    do_vblank(5, 1'b1);
    do_fstart();
    do_line(8, b, -1);
    do_line(8, b, -1);
    do_vblank(10, 1'b1);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      thresh = 8'($urandom);
      do_fstart();
      nl        = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 2;
      rst_frame = ($urandom_range(0, 9) == 0);
      rst_line  = $urandom_range(0, nl - 1);
      for (int l = 0; l < nl; l++) begin
        if ($urandom_range(0, 3) == 0) thresh = 8'($urandom);
        n = ($urandom_range(0, 9) < 7) ? 8 : $urandom_range(1, 12);
        for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
        rst_at = (rst_frame && l == rst_line) ? $urandom_range(0, n - 1) : -1;
        do_line(n, b, rst_at);
      end
      do_vblank($urandom_range(3, 6), 1'($urandom_range(0, 1)));
    end

    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    chk("final_queue0_empty", 32'(exp_q0.size()), 32'd0);
    chk("final_queue1_empty", 32'(exp_q1.size()), 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("frame_start_count_dut%0d", i), 32'(start_seen[i]), 32'(start_exp));
      chk($sformatf("frame_done_count_dut%0d", i), 32'(done_seen[i]), 32'(done_exp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
